// File: rtl/clock_time_counter.sv
// ============================================================================
// clock_time_counter
// ----------------------------------------------------------------------------
// Timekeeping core for the digital clock. It divides clk down to a 1 Hz tick
// and keeps a 24-hour time of day (00:00:00 - 23:59:59). Hours and minutes can
// be set by hand from push-button pulses while in SET mode.
//
// Parameters:
//   CLK_HZ   - input clock frequency; one second spans CLK_HZ cycles
//   PRESC_W  - prescaler width; 2**PRESC_W must exceed CLK_HZ-1
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   run_en    in   1 = time advances, 0 = paused (RUN only)
//   set_mode  in   1 = SET mode, 0 = RUN mode
//   inc_hour  in   one-cycle pulse, hours+1 (SET only)
//   inc_min   in   one-cycle pulse, minutes+1 (SET only)
//   hours     out  0-23, binary
//   minutes   out  0-59, binary
//   seconds   out  0-59, binary
//   sec_tick  out  one-cycle pulse coincident with each seconds update
//   day_roll  out  one-cycle pulse when the time wraps to 00:00:00
// ============================================================================
module clock_time_counter #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int PRESC_W = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_en,
    input  logic       set_mode,
    input  logic       inc_hour,
    input  logic       inc_min,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       sec_tick,
    output logic       day_roll
);

    localparam logic ST_RUN = 1'b0;
    localparam logic ST_SET = 1'b1;

    localparam logic [PRESC_W-1:0] LP_PRESC_TC = PRESC_W'(CLK_HZ - 1);

    logic               r_state;
    logic [PRESC_W-1:0] r_presc;
    logic [4:0]         r_hours;
    logic [5:0]         r_minutes;
    logic [5:0]         r_seconds;
    logic               r_sec_tick;
    logic               r_day_roll;

    logic               w_state_next;
    logic               w_presc_tc;
    logic               w_sec_wrap;
    logic               w_min_wrap;
    logic               w_hour_wrap;

    // The mode applied on an edge is the next state, so a switch into SET on
    // a terminal-count cycle suppresses that tick and clears seconds at once.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (set_mode)  w_state_next = ST_SET;
            ST_SET:  if (!set_mode) w_state_next = ST_RUN;
            default: w_state_next = ST_RUN;
        endcase
    end

    assign w_presc_tc  = (r_presc   == LP_PRESC_TC);
    assign w_sec_wrap  = (r_seconds == 6'd59);
    assign w_min_wrap  = (r_minutes == 6'd59);
    assign w_hour_wrap = (r_hours   == 5'd23);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_presc    <= '0;
            r_hours    <= '0;
            r_minutes  <= '0;
            r_seconds  <= '0;
            r_sec_tick <= 1'b0;
            r_day_roll <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sec_tick <= 1'b0;
            r_day_roll <= 1'b0;

            if (w_state_next == ST_SET) begin
                // Holding the prescaler at zero makes the first tick after
                // leaving SET land exactly one full second later.
                r_presc   <= '0;
                r_seconds <= '0;
                if (inc_hour) begin
                    r_hours <= w_hour_wrap ? '0 : r_hours + 5'd1;
                end
                if (inc_min) begin
                    r_minutes <= w_min_wrap ? '0 : r_minutes + 6'd1;
                end
            end else if (run_en) begin
                if (w_presc_tc) begin
                    r_presc    <= '0;
                    r_sec_tick <= 1'b1;
                    if (w_sec_wrap) begin
                        r_seconds <= '0;
                        if (w_min_wrap) begin
                            r_minutes <= '0;
                            if (w_hour_wrap) begin
                                r_hours    <= '0;
                                r_day_roll <= 1'b1;
                            end else begin
                                r_hours <= r_hours + 5'd1;
                            end
                        end else begin
                            r_minutes <= r_minutes + 6'd1;
                        end
                    end else begin
                        r_seconds <= r_seconds + 6'd1;
                    end
                end else begin
                    r_presc <= r_presc + PRESC_W'(1);
                end
            end
        end
    end

    assign hours    = r_hours;
    assign minutes  = r_minutes;
    assign seconds  = r_seconds;
    assign sec_tick = r_sec_tick;
    assign day_roll = r_day_roll;

endmodule

// File: tb/tb_clock_time_counter.sv
// ============================================================================
// tb_clock_time_counter
// ----------------------------------------------------------------------------
// Self-checking bench for clock_time_counter with CLK_HZ=4. Every step is
// compared against a reference model that tracks the time as seconds-of-day
// plus the number of running cycles within the current second. A vector table
// covers the basic behaviour, hand-written sequences cover the multi-cycle
// corner cases, and a randomized phase exercises mode/pause/reset mixes.
// ============================================================================
module tb_clock_time_counter;

    localparam int CLK_HZ = 4;

    logic       clk;
    logic       reset;
    logic       run_en;
    logic       set_mode;
    logic       inc_hour;
    logic       inc_min;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       sec_tick;
    logic       day_roll;

    clock_time_counter #(
        .CLK_HZ  (CLK_HZ),
        .PRESC_W (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run_en   (run_en),
        .set_mode (set_mode),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .sec_tick (sec_tick),
        .day_roll (day_roll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time of day in seconds, cycles elapsed in this second.
    int m_t    = 0;
    int m_ph   = 0;
    bit m_tick = 1'b0;
    bit m_roll = 1'b0;

    typedef struct {
        bit rst;
        bit set;
        bit run;
        bit ih;
        bit im;
        int h;
        int m;
        int s;
        bit tick;
        bit roll;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input bit rst, input bit set, input bit run,
                                input bit ih, input bit im, input int h,
                                input int m, input int s, input bit tick,
                                input bit roll);
        vec_t v;
        v.rst = rst; v.set = set; v.run = run; v.ih = ih; v.im = im;
        v.h = h; v.m = m; v.s = s; v.tick = tick; v.roll = roll;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit rst, input bit set, input bit run,
                                input bit ih, input bit im);
        int h;
        int m;
        m_tick = 1'b0;
        m_roll = 1'b0;
        if (rst) begin
            m_t  = 0;
            m_ph = 0;
        end else if (set) begin
            m_ph = 0;
            h = m_t / 3600;
            m = (m_t / 60) % 60;
            if (ih) h = (h + 1) % 24;
            if (im) m = (m + 1) % 60;
            m_t = h * 3600 + m * 60;
        end else if (run) begin
            m_ph++;
            if (m_ph == CLK_HZ) begin
                m_ph   = 0;
                m_t    = (m_t + 1) % 86400;
                m_tick = 1'b1;
                m_roll = (m_t == 0);
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, and check all outputs vs the model.
    task automatic step(input bit rst, input bit set, input bit run,
                        input bit ih, input bit im);
        reset    = rst;
        set_mode = set;
        run_en   = run;
        inc_hour = ih;
        inc_min  = im;
        @(posedge clk);
        #1;
        model_update(rst, set, run, ih, im);
        chk("model_hours",    int'(hours),    m_t / 3600);
        chk("model_minutes",  int'(minutes),  (m_t / 60) % 60);
        chk("model_seconds",  int'(seconds),  m_t % 60);
        chk("model_sec_tick", int'(sec_tick), int'(m_tick));
        chk("model_day_roll", int'(day_roll), int'(m_roll));
    endtask

    task automatic chk_time(input string nm, input int h, input int m, input int s);
        chk({nm, "_h"}, int'(hours),   h);
        chk({nm, "_m"}, int'(minutes), m);
        chk({nm, "_s"}, int'(seconds), s);
    endtask

    initial begin
        int roll_cnt;
        int roll_tick_ok;
        bit r_set;
        bit r_run;

        reset = 1'b0; set_mode = 1'b0; run_en = 1'b0;
        inc_hour = 1'b0; inc_min = 1'b0;

        // ---------------- vector table ----------------
        vt.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        for (int c = 1; c <= 12; c++)
            vt.push_back(mk(0, 0, 1, 0, 0,  0, 0, c / 4, (c % 4) == 0, 0));
        vt.push_back(mk(0, 1, 1, 0, 0,  0, 0, 0, 0, 0)); // SET clears seconds, run_en ignored
        vt.push_back(mk(0, 1, 0, 1, 0,  1, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 1, 1,  2, 1, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 1,  2, 2, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,  2, 2, 0, 0, 0)); // paused RUN
        vt.push_back(mk(0, 0, 1, 1, 1,  2, 2, 0, 0, 0)); // RUN ignores inc pulses
        vt.push_back(mk(0, 0, 1, 0, 0,  2, 2, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 0,  2, 2, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 0,  2, 2, 1, 1, 0)); // 4th RUN cycle after SET
        vt.push_back(mk(1, 1, 1, 1, 1,  0, 0, 0, 0, 0)); // reset overrides all

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].set, vt[i].run, vt[i].ih, vt[i].im);
            chk("vec_hours",    int'(hours),    vt[i].h);
            chk("vec_minutes",  int'(minutes),  vt[i].m);
            chk("vec_seconds",  int'(seconds),  vt[i].s);
            chk("vec_sec_tick", int'(sec_tick), int'(vt[i].tick));
            chk("vec_day_roll", int'(day_roll), int'(vt[i].roll));
        end

        // ---------------- day rollover ----------------
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 23; i++) step(0, 1, 0, 1, 0);
        for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 1);
        chk_time("roll_set", 23, 59, 0);
        roll_cnt = 0;
        roll_tick_ok = 1;
        for (int c = 1; c <= 240; c++) begin
            step(0, 0, 1, 0, 0);
            if (c == 236) chk_time("roll_pre", 23, 59, 59);
            if (day_roll) begin
                roll_cnt++;
                if (!sec_tick) roll_tick_ok = 0;
            end
        end
        chk_time("roll_post", 0, 0, 0);
        chk("roll_count", roll_cnt, 1);
        chk("roll_with_tick", roll_tick_ok, 1);

        // ---------------- simultaneous inc in SET ----------------
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 1);
        step(0, 1, 1, 1, 1);
        chk_time("both_inc", 6, 8, 0);
        chk("both_inc_tick", int'(sec_tick), 0);

        // ---------------- pause mid-second ----------------
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);   // prescaler now at 2
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0);
            chk("pause_tick", int'(sec_tick), 0);
            chk("pause_sec", int'(seconds), 0);
        end
        step(0, 0, 1, 0, 0);
        chk("resume1_tick", int'(sec_tick), 0);
        step(0, 0, 1, 0, 0);
        chk("resume2_tick", int'(sec_tick), 1);
        chk("resume2_sec", int'(seconds), 1);

        // ---------------- SET on terminal count ----------------
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 236; i++) step(0, 0, 1, 0, 0);
        chk_time("tc_pre", 0, 0, 59);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("tc_set_tick", int'(sec_tick), 0);
        chk_time("tc_set", 0, 0, 0);

        // ---------------- reset mid-count ----------------
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 1, 0);
        for (int i = 0; i < 34; i++) step(0, 1, 0, 0, 1);
        for (int i = 0; i < 224; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_time("mid_pre", 12, 34, 56);
        step(1, 0, 1, 0, 0);
        chk_time("mid_rst", 0, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            step(0, 0, 1, 0, 0);
            chk("mid_first_tick", int'(sec_tick), (c == 4) ? 1 : 0);
        end

        // ---------------- randomized ----------------
        r_set = 1'b0;
        r_run = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) r_set = ~r_set;
            if ($urandom_range(0, 29) == 0) r_run = ~r_run;
            step($urandom_range(0, 299) == 0, r_set, r_run,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
